// File: rtl/ascii2bcd_parser_if.sv
// ascii2bcd_parser_if
//   Character-in / number-out bundle for the ASCII-to-BCD line parser.
//
//   Signals:
//     ascii_in    [6:0]        received character code
//     ascii_valid              ascii_in is valid this cycle (one char per cycle)
//     bcd_out     [4*DIGITS-1:0] parsed digits, right-aligned
//     dp_pos      [2:0]        digits after the decimal point
//     digit_cnt   [2:0]        number of digits held in bcd_out
//     done                     one-cycle pulse: new number published
//     err                      one-cycle pulse: malformed line discarded
//     busy                     a line is in progress
//
//   Modports:
//     master : character source / result consumer
//     slave  : the parser itself
interface ascii2bcd_parser_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          ascii_in;
  logic                ascii_valid;
  logic [4*DIGITS-1:0] bcd_out;
  logic [2:0]          dp_pos;
  logic [2:0]          digit_cnt;
  logic                done;
  logic                err;
  logic                busy;

  modport master (
    output ascii_in,
    output ascii_valid,
    input  bcd_out,
    input  dp_pos,
    input  digit_cnt,
    input  done,
    input  err,
    input  busy
  );

  modport slave (
    input  ascii_in,
    input  ascii_valid,
    output bcd_out,
    output dp_pos,
    output digit_cnt,
    output done,
    output err,
    output busy
  );
endinterface

// File: rtl/ascii2bcd_parser.sv
// ascii2bcd_parser
//   Turns a typed line of ASCII characters (digits, an optional decimal
//   point, blanks, CR/LF terminator) into right-aligned packed BCD digits
//   plus the count of fractional digits. A finished line publishes the
//   number with a one-cycle done pulse; a malformed line is swallowed up to
//   its terminator and reported with a one-cycle err pulse. Published
//   outputs only change together with done.
//
//   Ports:
//     clk  - system clock
//     rst  - synchronous reset, active-high (abandons any line, no pulse)
//     bus  - ascii2bcd_parser_if.slave (ascii_in/ascii_valid in;
//            bcd_out/dp_pos/digit_cnt/done/err/busy out)
//
//   Parameters:
//     DIGITS - maximum digits per number (1..7), bcd_out is 4*DIGITS wide
//
//   Build option:
//     ASCII_BS_EN - when defined, backspace (0x08) edits the line being
//                   typed; when undefined, 0x08 is an illegal character.
module ascii2bcd_parser #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  ascii2bcd_parser_if.slave bus
);

  localparam int         W        = 4 * DIGITS;
  localparam logic [2:0] DIGITS_C = 3'(DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIGITS,
    ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    C_DIGIT,
    C_DOT,
    C_TERM,
    C_SPACE,
    C_BS,
    C_ILLEGAL
  } char_class_t;

  state_t      state_reg;
  logic [W-1:0] work_buf_reg;
  logic [2:0]  work_cnt_reg;
  logic [2:0]  frac_cnt_reg;
  logic        dp_seen_reg;

  logic [W-1:0] bcd_reg;
  logic [2:0]  dp_pos_reg;
  logic [2:0]  digit_cnt_reg;
  logic        done_reg;
  logic        err_reg;

  char_class_t char_class;
  logic [W-1:0] buf_shl;

  // ---------------------------------------------------------------------
  // Character classification
  // ---------------------------------------------------------------------
  always_comb begin
    char_class = C_ILLEGAL;
    if (bus.ascii_in >= 7'h30 && bus.ascii_in <= 7'h39) begin
      char_class = C_DIGIT;
    end else if (bus.ascii_in == 7'h2E) begin
      char_class = C_DOT;
    end else if (bus.ascii_in == 7'h0D || bus.ascii_in == 7'h0A) begin
      char_class = C_TERM;
    end else if (bus.ascii_in == 7'h20) begin
      char_class = C_SPACE;
    end
`ifdef ASCII_BS_EN
    else if (bus.ascii_in == 7'h08) begin
      char_class = C_BS;
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Nibble shifters for the working buffer.
  // Left shift appends the incoming digit (low nibble of its ASCII code)
  // as the new least significant digit.
  // ---------------------------------------------------------------------
  assign buf_shl[3:0] = bus.ascii_in[3:0];

  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_shl
    assign buf_shl[4*gi +: 4] = work_buf_reg[4*(gi-1) +: 4];
  end

`ifdef ASCII_BS_EN
  // Right shift drops the last typed digit.
  logic [W-1:0] buf_shr;

  assign buf_shr[W-1 -: 4] = 4'h0;

  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_shr
    assign buf_shr[4*(gi-1) +: 4] = work_buf_reg[4*gi +: 4];
  end
`endif

  // ---------------------------------------------------------------------
  // Line FSM with registered results
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      work_buf_reg  <= '0;
      work_cnt_reg  <= '0;
      frac_cnt_reg  <= '0;
      dp_seen_reg   <= 1'b0;
      bcd_reg       <= '0;
      dp_pos_reg    <= '0;
      digit_cnt_reg <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      // Pulses last exactly one cycle.
      done_reg <= 1'b0;
      err_reg  <= 1'b0;

      if (bus.ascii_valid) begin
        unique case (state_reg)
          ST_IDLE: begin
            case (char_class)
              C_DIGIT: begin
                work_buf_reg <= W'(bus.ascii_in[3:0]);
                work_cnt_reg <= 3'd1;
                state_reg    <= ST_DIGITS;
              end
              C_DOT: begin
                dp_seen_reg <= 1'b1;
                state_reg   <= ST_DIGITS;
              end
              // Blank lines and stray blanks are ignored; a backspace
              // with nothing typed has nothing to edit.
              C_TERM, C_SPACE, C_BS: ;
              default: state_reg <= ST_ERROR;
            endcase
          end

          ST_DIGITS: begin
            case (char_class)
              C_DIGIT: begin
                if (work_cnt_reg == DIGITS_C) begin
                  state_reg <= ST_ERROR;
                end else begin
                  work_buf_reg <= buf_shl;
                  work_cnt_reg <= work_cnt_reg + 3'd1;
                  if (dp_seen_reg) begin
                    frac_cnt_reg <= frac_cnt_reg + 3'd1;
                  end
                end
              end

              C_DOT: begin
                if (dp_seen_reg) begin
                  state_reg <= ST_ERROR;
                end else begin
                  dp_seen_reg <= 1'b1;
                end
              end

              C_TERM: begin
                // A line consisting of only a dot carries no number.
                if (work_cnt_reg != 3'd0) begin
                  bcd_reg       <= work_buf_reg;
                  digit_cnt_reg <= work_cnt_reg;
                  dp_pos_reg    <= frac_cnt_reg;
                  done_reg      <= 1'b1;
                end else begin
                  err_reg <= 1'b1;
                end
                state_reg    <= ST_IDLE;
                work_buf_reg <= '0;
                work_cnt_reg <= '0;
                frac_cnt_reg <= '0;
                dp_seen_reg  <= 1'b0;
              end

`ifdef ASCII_BS_EN
              C_BS: begin
                if (dp_seen_reg && frac_cnt_reg == 3'd0) begin
                  // Undo the dot before touching any digit.
                  dp_seen_reg <= 1'b0;
                end else if (work_cnt_reg != 3'd0) begin
                  work_buf_reg <= buf_shr;
                  work_cnt_reg <= work_cnt_reg - 3'd1;
                  if (dp_seen_reg) begin
                    frac_cnt_reg <= frac_cnt_reg - 3'd1;
                  end
                end
              end
`endif

              default: state_reg <= ST_ERROR;
            endcase
          end

          ST_ERROR: begin
            // Everything up to the terminator is discarded; published
            // outputs keep the last good number.
            if (char_class == C_TERM) begin
              err_reg      <= 1'b1;
              state_reg    <= ST_IDLE;
              work_buf_reg <= '0;
              work_cnt_reg <= '0;
              frac_cnt_reg <= '0;
              dp_seen_reg  <= 1'b0;
            end
          end

          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.bcd_out   = bcd_reg;
  assign bus.dp_pos    = dp_pos_reg;
  assign bus.digit_cnt = digit_cnt_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.busy      = (state_reg != ST_IDLE);

endmodule
